pixie_dma_scheduler: RTL and testbench
======================================

PIXIE_DMA_SCHEDULER -- requirements
Module: pixie_dma_scheduler

Interface
REQ-001 SHALL have parameter BYTES_PER_LINE, default 14, machine cycles per scan line.
REQ-002 SHALL have parameter LINES_PER_FRAME, default 262, lines per frame.
REQ-003 SHALL have parameter ACTIVE_START, default 64, first line with display DMA.
REQ-004 SHALL have parameter ACTIVE_LINES, default 128, number of lines with display DMA.
REQ-005 SHALL have parameter INT_LINE, default 62, line on which INT asserts.
REQ-006 SHALL have parameter DMA_BYTES, default 8, DMA transfers per active line.
REQ-007 SHALL have ports clk (input, 1, sole clock) and reset_n (input, 1, asynchronous active-low reset).
REQ-008 SHALL have port clk_enable (input, 1): one pulse per CDP1802 machine cycle.
REQ-009 SHALL have port SC (input, 2): CPU state code; 2'b10 is a DMA acknowledge.
REQ-010 SHALL have ports disp_on and disp_off (input, 1 each): display-enable strobes.
REQ-011 SHALL have port DMAO (output, 1): active-low DMA-out request.
REQ-012 SHALL have port INT (output, 1): active-high interrupt request.
REQ-013 SHALL have port EFx (output, 1): active-low frame flag.
REQ-014 SHALL have ports line_start and frame_start (output, 1 each): one-clk pulses at h=0 and at h=0,v=0.
REQ-015 SHALL have ports hcount (output, 4) and vcount (output, 9): current machine-cycle and line position.
REQ-016 SHALL have port dma_underrun (output, 1): sticky flag for a short DMA burst.

Function
REQ-017 SHALL advance hcount on each clk_enable; at BYTES_PER_LINE-1 wrap to 0 and advance vcount; at LINES_PER_FRAME-1 wrap vcount to 0.
REQ-018 SHALL leave all state unchanged when clk_enable=0.
REQ-019 SHALL set display_enabled on disp_on and clear it on disp_off; when both strobe in one cycle, disp_on SHALL win.
REQ-020 SHALL implement states IDLE (display off), VBLANK, DMA_BURST and LINE_TAIL.
REQ-021 SHALL move to IDLE from any state on the enabled cycle in which display_enabled clears.
REQ-022 SHALL move from IDLE to VBLANK at the next h=0 after display_enabled sets.
REQ-023 SHALL move from VBLANK to DMA_BURST at h=1 of lines ACTIVE_START..ACTIVE_START+ACTIVE_LINES-1.
REQ-024 SHALL drive DMAO low only in DMA_BURST.
REQ-025 SHALL count SC==2'b10 acknowledges during DMA_BURST on enabled cycles, and leave DMA_BURST for LINE_TAIL after DMA_BYTES acknowledges or at h=DMA_BYTES+1, whichever comes first.
REQ-026 SHALL set dma_underrun when the acknowledge count is less than DMA_BYTES on leaving DMA_BURST via timeout; the flag SHALL clear only on reset.
REQ-027 SHALL NOT set dma_underrun when a burst is aborted by disp_off.
REQ-028 SHALL move from LINE_TAIL to DMA_BURST on the next active line, or to VBLANK after the last active line.
REQ-029 SHALL assert INT only while vcount is INT_LINE or INT_LINE+1 and display_enabled=1.
REQ-030 SHALL drive EFx low for lines ACTIVE_START-4..ACTIVE_START-1 and for lines ACTIVE_START+ACTIVE_LINES-4..ACTIVE_START+ACTIVE_LINES-1, independent of display_enabled.
REQ-031 SHALL register all outputs, giving one clk of latency after the enabled cycle that changes them.

Reset
REQ-032 SHALL, while reset_n=0, force hcount=0, vcount=0, state=IDLE, display_enabled=0, DMAO=1, INT=0, EFx=1, line_start=0, frame_start=0 and dma_underrun=0.
REQ-033 SHALL, on reset mid-burst, release DMAO and discard the acknowledge count.

Configuration
REQ-034 SHALL, with PIXIE_DMA_STATS_EN defined, add outputs frame_count (16-bit, increments on frame_start, wraps) and underrun_count (8-bit, saturates at 255), both reset to 0.
REQ-035 SHALL, without PIXIE_DMA_STATS_EN, omit those ports and their logic.

Structure
REQ-036 SHALL take the state enum, default timing constants and the SC code localparams from a shared package pixie_pkg.
REQ-037 SHALL place the hcount/vcount counters and the line_start/frame_start pulses in sub-module pixie_line_timer.

Verification
REQ-038 SHALL verify: with clk_enable every cycle and no disp_on, frame_start recurs every 3668 enabled cycles, DMAO stays 1 and INT stays 0.
REQ-039 SHALL verify: disp_on plus 8 acks on each active line gives DMAO low for exactly 8 enabled cycles per line, on lines 64..191, and dma_underrun=0.
REQ-040 SHALL verify: only 5 acks on line 70 leaves DMAO low through h=9, then dma_underrun=1 and stays 1.
REQ-041 SHALL verify: disp_off at h=4 of line 100 drives DMAO=1 on the next clk and leaves dma_underrun=0.
REQ-042 SHALL verify: disp_on and disp_off in the same cycle leave display_enabled=1, and INT is high on lines 62-63 only.
REQ-043 SHALL verify: reset_n low at h=3 of an active line asynchronously forces DMAO=1, vcount=0 and state=IDLE.

Source files
------------

// File: rtl/pixie_pkg.sv
// Shared definitions for the Pixie DMA scheduler: FSM state encoding, default
// NTSC-style frame timing and the CDP1802 state-code value for a DMA cycle.
package pixie_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_VBLANK    = 2'd1,
    ST_DMA_BURST = 2'd2,
    ST_LINE_TAIL = 2'd3
  } pixie_state_e;

  localparam int unsigned PIXIE_BYTES_PER_LINE  = 14;
  localparam int unsigned PIXIE_LINES_PER_FRAME = 262;
  localparam int unsigned PIXIE_ACTIVE_START    = 64;
  localparam int unsigned PIXIE_ACTIVE_LINES    = 128;
  localparam int unsigned PIXIE_INT_LINE        = 62;
  localparam int unsigned PIXIE_DMA_BYTES       = 8;

  localparam logic [1:0] SC_DMA_ACK = 2'b10;

endpackage

// File: rtl/pixie_line_timer.sv
// Machine-cycle (hcount) and scan-line (vcount) counters with registered
// line_start / frame_start pulses; exposes the next vcount for aligned outputs.
module pixie_line_timer
  import pixie_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE  = PIXIE_BYTES_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = PIXIE_LINES_PER_FRAME
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_enable,
  output logic [3:0] hcount,
  output logic [8:0] vcount,
  output logic [8:0] vcount_next,
  output logic       line_start,
  output logic       frame_start
);

  localparam logic [3:0] H_LAST = 4'(BYTES_PER_LINE - 1);
  localparam logic [8:0] V_LAST = 9'(LINES_PER_FRAME - 1);

  logic h_wrap;

  assign h_wrap = clk_enable && (hcount == H_LAST);

  always_comb begin
    vcount_next = vcount;
    if (h_wrap) vcount_next = (vcount == V_LAST) ? '0 : vcount + 9'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hcount      <= '0;
      vcount      <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= h_wrap;
      frame_start <= h_wrap && (vcount == V_LAST);
      vcount      <= vcount_next;
      if (clk_enable) hcount <= h_wrap ? '0 : hcount + 4'd1;
    end
  end

endmodule

// File: rtl/pixie_dma_scheduler.sv
// CDP1861-style display DMA scheduler: per-line DMA bursts, INT and EFx timing.
// Optional statistics outputs enabled by defining PIXIE_DMA_STATS_EN.
module pixie_dma_scheduler
  import pixie_pkg::*;
#(
  parameter int unsigned BYTES_PER_LINE  = PIXIE_BYTES_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = PIXIE_LINES_PER_FRAME,
  parameter int unsigned ACTIVE_START    = PIXIE_ACTIVE_START,
  parameter int unsigned ACTIVE_LINES    = PIXIE_ACTIVE_LINES,
  parameter int unsigned INT_LINE        = PIXIE_INT_LINE,
  parameter int unsigned DMA_BYTES       = PIXIE_DMA_BYTES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_enable,
  input  logic [1:0] SC,
  input  logic       disp_on,
  input  logic       disp_off,
  output logic       DMAO,
  output logic       INT,
  output logic       EFx,
  output logic       line_start,
  output logic       frame_start,
  output logic [3:0] hcount,
  output logic [8:0] vcount,
  output logic       dma_underrun
`ifdef PIXIE_DMA_STATS_EN
  ,
  output logic [15:0] frame_count,
  output logic [7:0]  underrun_count
`endif
);

  localparam logic [3:0] H_LAST        = 4'(BYTES_PER_LINE - 1);
  localparam logic [3:0] H_BURST_START = 4'd1;
  localparam logic [3:0] H_BURST_END   = 4'(DMA_BYTES + 1);
  localparam logic [3:0] ACK_TARGET    = 4'(DMA_BYTES);
  localparam logic [8:0] V_ACT_FIRST   = 9'(ACTIVE_START);
  localparam logic [8:0] V_ACT_LAST    = 9'(ACTIVE_START + ACTIVE_LINES - 1);
  localparam logic [8:0] V_EF1_FIRST   = 9'(ACTIVE_START - 4);
  localparam logic [8:0] V_EF2_FIRST   = 9'(ACTIVE_START + ACTIVE_LINES - 4);
  localparam logic [8:0] V_INT0        = 9'(INT_LINE);
  localparam logic [8:0] V_INT1        = 9'(INT_LINE + 1);

  pixie_state_e state, state_nxt;
  logic         display_enabled, de_nxt;
  logic [3:0]   ack_cnt, ack_nxt;
  logic [8:0]   vcount_next;
  logic         line_active, underrun_evt, ef_zone;

  pixie_line_timer #(
    .BYTES_PER_LINE (BYTES_PER_LINE),
    .LINES_PER_FRAME(LINES_PER_FRAME)
  ) u_line_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .hcount     (hcount),
    .vcount     (vcount),
    .vcount_next(vcount_next),
    .line_start (line_start),
    .frame_start(frame_start)
  );

  assign line_active = (vcount >= V_ACT_FIRST) && (vcount <= V_ACT_LAST);
  assign ef_zone = ((vcount_next >= V_EF1_FIRST) && (vcount_next < V_ACT_FIRST)) ||
                   ((vcount_next >= V_EF2_FIRST) && (vcount_next <= V_ACT_LAST));

  always_comb begin
    de_nxt       = display_enabled;
    state_nxt    = state;
    ack_nxt      = ack_cnt;
    underrun_evt = 1'b0;
    if (clk_enable) begin
      if (disp_on) de_nxt = 1'b1;
      else if (disp_off) de_nxt = 1'b0;
      // A display-off abort takes priority, so an interrupted burst never flags underrun.
      if (display_enabled && !de_nxt) begin
        state_nxt = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE:
            if (display_enabled && hcount == '0) state_nxt = ST_VBLANK;
          ST_VBLANK:
            if (hcount == H_BURST_START && line_active) begin
              state_nxt = ST_DMA_BURST;
              ack_nxt   = '0;
            end
          ST_DMA_BURST: begin
            if (SC == SC_DMA_ACK) ack_nxt = ack_cnt + 4'd1;
            if (ack_nxt == ACK_TARGET) begin
              state_nxt = ST_LINE_TAIL;
            end else if (hcount == H_BURST_END) begin
              state_nxt    = ST_LINE_TAIL;
              underrun_evt = 1'b1;
            end
          end
          ST_LINE_TAIL:
            if (hcount == H_LAST && vcount == V_ACT_LAST) begin
              state_nxt = ST_VBLANK;
            end else if (hcount == H_BURST_START && line_active) begin
              state_nxt = ST_DMA_BURST;
              ack_nxt   = '0;
            end
        endcase
      end
    end
  end

  // Outputs are registered from next-state values so they line up with hcount/vcount.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      display_enabled <= 1'b0;
      ack_cnt         <= '0;
      DMAO            <= 1'b1;
      INT             <= 1'b0;
      EFx             <= 1'b1;
      dma_underrun    <= 1'b0;
    end else begin
      state           <= state_nxt;
      display_enabled <= de_nxt;
      ack_cnt         <= ack_nxt;
      DMAO            <= (state_nxt != ST_DMA_BURST);
      INT             <= de_nxt && ((vcount_next == V_INT0) || (vcount_next == V_INT1));
      EFx             <= !ef_zone;
      if (underrun_evt) dma_underrun <= 1'b1;
    end
  end

`ifdef PIXIE_DMA_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count    <= '0;
      underrun_count <= '0;
    end else begin
      if (frame_start) frame_count <= frame_count + 16'd1;
      if (underrun_evt && underrun_count != 8'hFF) underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Directed self-checking bench for pixie_dma_scheduler with a position model
// tracking expected hcount/vcount, DMAO, INT and EFx on every step.
module tb_pixie_dma_scheduler;
  import pixie_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       clk_enable = 1'b0;
  logic [1:0] SC = 2'b00;
  logic       disp_on = 1'b0;
  logic       disp_off = 1'b0;
  logic       DMAO, INT, EFx, line_start, frame_start, dma_underrun;
  logic [3:0] hcount;
  logic [8:0] vcount;
`ifdef PIXIE_DMA_STATS_EN
  logic [15:0] frame_count;
  logic [7:0]  underrun_count;
`endif

  pixie_dma_scheduler dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_enable  (clk_enable),
    .SC          (SC),
    .disp_on     (disp_on),
    .disp_off    (disp_off),
    .DMAO        (DMAO),
    .INT         (INT),
    .EFx         (EFx),
    .line_start  (line_start),
    .frame_start (frame_start),
    .hcount      (hcount),
    .vcount      (vcount),
    .dma_underrun(dma_underrun)
`ifdef PIXIE_DMA_STATS_EN
    ,
    .frame_count   (frame_count),
    .underrun_count(underrun_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int th = 0, tv = 0;
  bit de_model = 1'b0;
  bit pc_en = 1'b0;
  bit wrapped;
  int short_line = -1, short_acks = 8;
  int dmao_low_cnt = 0, int_hi_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d (v=%0d h=%0d)", tag, obs, exp, tv, th);
    end
  endtask

  function automatic bit is_active(input int v);
    return (v >= 64) && (v <= 191);
  endfunction

  function automatic bit ef_line(input int v);
    return ((v >= 60) && (v <= 63)) || ((v >= 188) && (v <= 191));
  endfunction

  // One clock: drive SC from the model position, advance the model, compare outputs.
  task automatic step();
    int  acks;
    bit  exp_dmao, exp_int;
    acks = (tv == short_line) ? short_acks : 8;
    SC = (is_active(tv) && th >= 2 && th < 2 + acks) ? 2'b10 : 2'b00;
    @(posedge clk);
    #1;
    wrapped = 1'b0;
    if (clk_enable) begin
      if (disp_on) de_model = 1'b1;
      else if (disp_off) de_model = 1'b0;
      if (th == 13) begin
        th = 0;
        wrapped = 1'b1;
        tv = (tv == 261) ? 0 : tv + 1;
      end else begin
        th++;
      end
    end
    exp_dmao = !(de_model && is_active(tv) && th >= 2 && th <= 9);
    exp_int  = de_model && (tv == 62 || tv == 63);
    if (clk_enable && !DMAO) dmao_low_cnt++;
    if (clk_enable && INT) int_hi_cnt++;
    if (pc_en) begin
      check("hcount", 32'(hcount), 32'(th));
      check("vcount", 32'(vcount), 32'(tv));
      check("line_start", 32'(line_start), 32'(wrapped));
      check("frame_start", 32'(frame_start), 32'(wrapped && tv == 0));
      check("DMAO", 32'(DMAO), 32'(exp_dmao));
      check("INT", 32'(INT), 32'(exp_int));
      check("EFx", 32'(EFx), 32'(!ef_line(tv)));
    end
  endtask

  task automatic run_to(input int v, input int h);
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 8000; i++) begin
      if (tv == v && th == h) begin
        reached = 1'b1;
        break;
      end
      step();
    end
    check("run_to_reached", 32'(reached), 32'd1);
  endtask

  initial begin
    int n;

    // Reset state
    clk_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hcount", 32'(hcount), 32'd0);
    check("rst_vcount", 32'(vcount), 32'd0);
    check("rst_DMAO", 32'(DMAO), 32'd1);
    check("rst_INT", 32'(INT), 32'd0);
    check("rst_EFx", 32'(EFx), 32'd1);
    check("rst_line_start", 32'(line_start), 32'd0);
    check("rst_frame_start", 32'(frame_start), 32'd0);
    check("rst_underrun", 32'(dma_underrun), 32'd0);
    check("rst_state", 32'(dut.state), 32'(ST_IDLE));
    check("rst_display_en", 32'(dut.display_enabled), 32'd0);
    reset_n = 1'b1;
    pc_en = 1'b1;

    // Clock enable held low: nothing moves
    clk_enable = 1'b0;
    repeat (3) step();
    check("hold_hcount", 32'(hcount), 32'd0);
    clk_enable = 1'b1;

    // Two frames with display off: frame period 14*262 enabled cycles
    for (int f = 0; f < 2; f++) begin
      n = 0;
      dmao_low_cnt = 0;
      int_hi_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
        step();
        n++;
        if (frame_start) break;
      end
      check("frame_period", 32'(n), 32'd3668);
      check("off_dmao_low", 32'(dmao_low_cnt), 32'd0);
      check("off_int_high", 32'(int_hi_cnt), 32'd0);
    end

    // Frame A: simultaneous strobes (disp_on wins), full acks, pause mid-burst
    disp_on = 1'b1;
    disp_off = 1'b1;
    dmao_low_cnt = 0;
    int_hi_cnt = 0;
    step();
    disp_on = 1'b0;
    disp_off = 1'b0;
    check("both_strobe_de", 32'(dut.display_enabled), 32'd1);
    run_to(66, 4);
    clk_enable = 1'b0;
    repeat (3) step();
    check("pause_hcount", 32'(hcount), 32'd4);
    check("pause_DMAO", 32'(DMAO), 32'd0);
    clk_enable = 1'b1;
    run_to(0, 0);
    check("frameA_dmao_low", 32'(dmao_low_cnt), 32'd1024);
    check("frameA_int_high", 32'(int_hi_cnt), 32'd28);
    check("frameA_underrun", 32'(dma_underrun), 32'd0);

    // Frame B: disp_off at h=4 of line 100 aborts the burst
    run_to(100, 4);
    disp_off = 1'b1;
    step();
    disp_off = 1'b0;
    check("abort_DMAO", 32'(DMAO), 32'd1);
    check("abort_state", 32'(dut.state), 32'(ST_IDLE));
    check("abort_de", 32'(dut.display_enabled), 32'd0);
    check("abort_underrun", 32'(dma_underrun), 32'd0);
    run_to(0, 0);
    check("frameB_underrun", 32'(dma_underrun), 32'd0);

    // Frame C: only 5 acks on line 70
    disp_on = 1'b1;
    step();
    disp_on = 1'b0;
    short_line = 70;
    short_acks = 5;
    run_to(70, 9);
    check("short_h9_DMAO", 32'(DMAO), 32'd0);
    check("short_h9_underrun", 32'(dma_underrun), 32'd0);
    step();
    check("short_h10_DMAO", 32'(DMAO), 32'd1);
    check("short_h10_underrun", 32'(dma_underrun), 32'd1);
    run_to(80, 3);
    check("sticky_underrun", 32'(dma_underrun), 32'd1);
    check("burst_DMAO", 32'(DMAO), 32'd0);

    // Asynchronous reset mid-burst, away from any clock edge
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_DMAO", 32'(DMAO), 32'd1);
    check("areset_vcount", 32'(vcount), 32'd0);
    check("areset_hcount", 32'(hcount), 32'd0);
    check("areset_state", 32'(dut.state), 32'(ST_IDLE));
    check("areset_underrun", 32'(dma_underrun), 32'd0);
    check("areset_ack_cnt", 32'(dut.ack_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
